// File: rtl/fft_power_pkg.sv
// Shared types and width helpers for the streaming power-spectrum averager.
//   state_e : ACCUM (accepting bins) / FLUSH (pipeline drain) / DRAIN (output)
//   clog2   : ceiling log2, used for bin-index widths
//   pwr_w   : width of one |X|^2 value for a given signed input width
//   acc_w   : accumulator width holding 2^avg_log2 summed powers
//   band_w  : width of a band sum over up to nbins averaged powers
package fft_power_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    DRAIN
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned pwr_w(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w,
                                        input int unsigned avg_log2);
    return pwr_w(data_w) + avg_log2;
  endfunction

  function automatic int unsigned band_w(input int unsigned data_w,
                                         input int unsigned nbins);
    return pwr_w(data_w) + clog2(nbins);
  endfunction

endpackage

// File: rtl/cplx_mag2.sv
// Squared magnitude re^2 + im^2 of a signed complex sample, with a valid/tag
// pipe travelling alongside the data.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   valid_i, tag_i    : sample present and its side-band tag
//   re_i, im_i        : signed real / imaginary parts
//   valid_o, tag_o    : delayed valid and tag, aligned with pwr_o
//   pwr_o             : re^2 + im^2 (unsigned, 2*DATA_W+1 bits)
// Stage 1 registers the two squares. Stage 2 is the adder driving pwr_o; its
// register is the caller's accumulator, so a sample entering at cycle T lands
// in that accumulator at T+2.
module cplx_mag2
  import fft_power_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int TAG_W  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic signed [DATA_W-1:0]  re_i,
  input  logic signed [DATA_W-1:0]  im_i,
  input  logic [TAG_W-1:0]          tag_i,
  output logic                      valid_o,
  output logic [pwr_w(DATA_W)-1:0]  pwr_o,
  output logic [TAG_W-1:0]          tag_o
);

  localparam int unsigned SQ_W = 2 * DATA_W;
  localparam int unsigned PW   = pwr_w(DATA_W);

  logic signed [SQ_W-1:0] re_ext, im_ext;
  logic signed [SQ_W-1:0] re_sq_q, im_sq_q;
  logic                   valid_q;
  logic [TAG_W-1:0]       tag_q;

  assign re_ext = SQ_W'(re_i);
  assign im_ext = SQ_W'(im_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        tag_q   <= tag_i;
        re_sq_q <= re_ext * re_ext;
        im_sq_q <= im_ext * im_ext;
      end
    end
  end

  // Squares are non-negative, so zero extension is exact.
  assign pwr_o   = PW'($unsigned(re_sq_q)) + PW'($unsigned(im_sq_q));
  assign valid_o = valid_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/fft_power_avg.sv
// Streaming power-spectrum averager fed directly by the FFT core.
// Bins arrive one per cycle (in_valid/in_ready, in_last on the final bin),
// |X|^2 is accumulated per bin over 2^AVG_LOG2 good frames, then the averaged
// spectrum drains serially (out_valid/out_ready, out_bin, out_last). While
// draining, the averaged powers of bins band_lo..band_hi are summed into
// band_power (band_valid pulses when it updates). frame_err pulses when
// in_last and the bin count disagree; that frame is discarded.
// Optional macro FFT_POWER_PEAK_EN: reports the strongest drained bin on
// peak_bin/peak_power (lowest index wins ties); otherwise both are 0.
module fft_power_avg
  import fft_power_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int NBINS    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int PWR_W    = pwr_w(DATA_W)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_W-1:0]          in_real,
  input  logic signed [DATA_W-1:0]          in_imag,
  input  logic                              in_last,
  input  logic [clog2(NBINS)-1:0]           band_lo,
  input  logic [clog2(NBINS)-1:0]           band_hi,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PWR_W-1:0]                  out_power,
  output logic [clog2(NBINS)-1:0]           out_bin,
  output logic                              out_last,
  output logic                              band_valid,
  output logic [band_w(DATA_W, NBINS)-1:0]  band_power,
  output logic                              frame_err,
  output logic [clog2(NBINS)-1:0]           peak_bin,
  output logic [PWR_W-1:0]                  peak_power
);

  localparam int unsigned BIN_W  = clog2(NBINS);
  localparam int unsigned ACC_W  = acc_w(DATA_W, AVG_LOG2);
  localparam int unsigned BAND_W = band_w(DATA_W, NBINS);
  localparam int unsigned FCNT_W = AVG_LOG2 + 1;
  localparam int unsigned NB     = NBINS;
  localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(NBINS - 1);
  localparam logic [BIN_W-1:0]  PENULT_BIN = BIN_W'(NBINS - 2);
  localparam logic [FCNT_W-1:0] LAST_FRM   = FCNT_W'((1 << AVG_LOG2) - 1);

  state_e              state_q;
  logic                in_ready_q;
  logic [BIN_W-1:0]    bin_cnt_q;
  logic [FCNT_W-1:0]   frm_cnt_q;
  logic                flush_q;
  logic                out_valid_q, out_last_q;
  logic [BIN_W-1:0]    out_bin_q, lo_q, hi_q;
  logic [BAND_W-1:0]   band_acc_q, band_power_q, band_next;
  logic                band_valid_q, frame_err_q;

  logic [ACC_W-1:0]    acc_q [NBINS];
  logic [ACC_W-1:0]    acc_d [NBINS];
  // Powers of the frame in progress; folded into acc_q only once the frame
  // is known to be good, so a malformed frame leaves no trace.
  logic [PWR_W-1:0]    frm_q [NBINS];
  logic [PWR_W-1:0]    frm_d [NBINS];

  logic                accept, at_last_bin, good_end, bad_end, drain_hs, in_band;
  logic                p_valid, p_commit;
  logic [PWR_W-1:0]    p_pwr;
  logic [BIN_W:0]      p_tag;
  logic [BIN_W-1:0]    p_bin;

  assign accept      = in_valid && in_ready_q;
  assign at_last_bin = (bin_cnt_q == LAST_BIN);
  assign good_end    = accept && in_last && at_last_bin;
  assign bad_end     = accept && (in_last != at_last_bin);
  assign drain_hs    = out_valid_q && out_ready;
  assign in_band     = (out_bin_q >= lo_q) && (out_bin_q <= hi_q);

  cplx_mag2 #(
    .DATA_W (DATA_W),
    .TAG_W  (BIN_W + 1)
  ) u_mag2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (accept),
    .re_i    (in_real),
    .im_i    (in_imag),
    .tag_i   ({good_end, bin_cnt_q}),
    .valid_o (p_valid),
    .pwr_o   (p_pwr),
    .tag_o   (p_tag)
  );

  assign p_commit = p_tag[BIN_W];
  assign p_bin    = p_tag[BIN_W-1:0];

  always_comb begin
    acc_d = acc_q;
    frm_d = frm_q;
    if (p_valid) begin
      frm_d[p_bin] = p_pwr;
      if (p_commit) begin
        for (int unsigned i = 0; i < NB; i++) begin
          acc_d[i] = acc_q[i] + ACC_W'(frm_d[i]);
        end
      end
    end
    if (drain_hs) acc_d[out_bin_q] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NB; i++) begin
        acc_q[i] <= '0;
        frm_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      frm_q <= frm_d;
    end
  end

  assign out_power = out_valid_q ? PWR_W'(acc_q[out_bin_q] >> AVG_LOG2) : '0;
  assign band_next = band_acc_q + (in_band ? BAND_W'(out_power) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      in_ready_q   <= 1'b1;
      bin_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      flush_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bin_q    <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      band_acc_q   <= '0;
      band_power_q <= '0;
      band_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      band_valid_q <= 1'b0;
      frame_err_q  <= bad_end;
      case (state_q)
        ACCUM: begin
          if (accept) begin
            bin_cnt_q <= (good_end || bad_end) ? '0 : bin_cnt_q + 1'b1;
            if (good_end) begin
              if (frm_cnt_q == LAST_FRM) begin
                frm_cnt_q  <= '0;
                state_q    <= FLUSH;
                in_ready_q <= 1'b0;
                flush_q    <= 1'b0;
              end else begin
                frm_cnt_q <= frm_cnt_q + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (flush_q) begin
            state_q     <= DRAIN;
            lo_q        <= band_lo;
            hi_q        <= band_hi;
            out_valid_q <= 1'b1;
            out_bin_q   <= '0;
            out_last_q  <= 1'b0;
            band_acc_q  <= '0;
          end else begin
            flush_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_hs) begin
            if (out_last_q) begin
              state_q      <= ACCUM;
              in_ready_q   <= 1'b1;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              out_bin_q    <= '0;
              band_power_q <= band_next;
              band_valid_q <= 1'b1;
            end else begin
              out_bin_q  <= out_bin_q + 1'b1;
              out_last_q <= (out_bin_q == PENULT_BIN);
              band_acc_q <= band_next;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_bin    = out_bin_q;
  assign out_last   = out_last_q;
  assign band_valid = band_valid_q;
  assign band_power = band_power_q;
  assign frame_err  = frame_err_q;

`ifdef FFT_POWER_PEAK_EN
  logic [BIN_W-1:0] pk_bin_run_q, peak_bin_q;
  logic [PWR_W-1:0] pk_pwr_run_q, peak_power_q;
  logic             pk_take;

  // Bin 0 seeds the running max; later bins must be strictly larger.
  assign pk_take = (out_bin_q == '0) || (out_power > pk_pwr_run_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_bin_run_q <= '0;
      pk_pwr_run_q <= '0;
      peak_bin_q   <= '0;
      peak_power_q <= '0;
    end else if (drain_hs) begin
      if (pk_take) begin
        pk_bin_run_q <= out_bin_q;
        pk_pwr_run_q <= out_power;
      end
      if (out_last_q) begin
        peak_bin_q   <= pk_take ? out_bin_q : pk_bin_run_q;
        peak_power_q <= pk_take ? out_power : pk_pwr_run_q;
      end
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_power = peak_power_q;
`else
  assign peak_bin   = '0;
  assign peak_power = '0;
`endif

endmodule

// File: tb/tb_fft_power_avg.sv
module tb_fft_power_avg;

  localparam int DW = 24;
  localparam int NB = 8;
  localparam int AL = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_last;
  logic signed [23:0] in_real, in_imag;
  logic [2:0]         band_lo, band_hi;
  logic               out_valid, out_ready, out_last;
  logic [48:0]        out_power;
  logic [2:0]         out_bin;
  logic               band_valid;
  logic [51:0]        band_power;
  logic               frame_err;
  logic [2:0]         peak_bin;
  logic [48:0]        peak_power;

  fft_power_avg #(
    .DATA_W   (DW),
    .NBINS    (NB),
    .AVG_LOG2 (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_last    (in_last),
    .band_lo    (band_lo),
    .band_hi    (band_hi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_power  (out_power),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .band_valid (band_valid),
    .band_power (band_power),
    .frame_err  (frame_err),
    .peak_bin   (peak_bin),
    .peak_power (peak_power)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              bin;
    longint unsigned pwr;
    bit              last;
  } exp_t;

  typedef struct {
    longint unsigned band;
    int              pk_bin;
    longint unsigned pk_pwr;
  } band_t;

  exp_t            sb_q[$];
  band_t           band_q[$];
  longint unsigned mdl_acc [NB];
  int              n_cmp = 0;
  int              n_err = 0;
  int              err_pulses = 0;
  bit              toggle_en = 1'b0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int re_of(input int mode, input int k);
    case (mode)
      0:       return k;
      1:       return -3;
      default: return -(1 << 23);
    endcase
  endfunction

  function automatic int im_of(input int mode);
    case (mode)
      0:       return 0;
      1:       return 4;
      default: return -(1 << 23);
    endcase
  endfunction

  // kind 0: well-formed frame; 1: in_last early on bin 5; 2: no in_last at all
  task automatic send_frame(input int mode, input int kind);
    int nbins;
    nbins = (kind == 1) ? 6 : NB;
    for (int k = 0; k < nbins; k++) begin
      in_valid = 1'b1;
      in_real  = 24'(re_of(mode, k));
      in_imag  = 24'(im_of(mode));
      in_last  = (kind == 0 && k == NB - 1) || (kind == 1 && k == 5);
      @(posedge clk); #1;
      if (kind == 0) begin
        mdl_acc[k] += longint'(re_of(mode, k)) * longint'(re_of(mode, k))
                    + longint'(im_of(mode)) * longint'(im_of(mode));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_drain(input int nbins, input bit with_band,
                              input int lo, input int hi);
    band_t b;
    b.band = 0; b.pk_bin = 0; b.pk_pwr = 0;
    for (int k = 0; k < nbins; k++) begin
      exp_t e;
      e.bin  = k;
      e.pwr  = mdl_acc[k] >> AL;
      e.last = (k == NB - 1);
      sb_q.push_back(e);
      if (k >= lo && k <= hi) b.band += e.pwr;
      if (k == 0 || e.pwr > b.pk_pwr) begin
        b.pk_pwr = e.pwr;
        b.pk_bin = k;
      end
    end
    for (int k = 0; k < NB; k++) mdl_acc[k] = 0;
    if (with_band) band_q.push_back(b);
  endtask

  task automatic wait_band(input bit pulse_in);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      if (band_valid) seen = 1'b1;
      else if (pulse_in) begin
        in_valid = ~in_valid;
        in_last  = 1'b1;
        in_real  = 24'sh7ffff0;
        in_imag  = 24'sh7ffff0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!seen) check("band_timeout", 0, 1);
  endtask

  task automatic run_spectrum(input int mode, input int lo, input int hi,
                              input bit toggle, input bit pulse_in);
    band_lo = 3'(lo);
    band_hi = 3'(hi);
    for (int f = 0; f < (1 << AL); f++) send_frame(mode, 0);
    expect_drain(NB, 1'b1, lo, hi);
    toggle_en = toggle;
    wait_band(pulse_in);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (out_valid) begin
      check("in_ready_drain", in_ready, 0);
      if (out_ready) begin
        if (sb_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_bin", out_bin, e.bin);
          check("out_power", out_power, e.pwr);
          check("out_last", out_last, e.last);
        end
      end
    end
    if (band_valid) begin
      if (band_q.size() == 0) check("band_unexpected", 1, 0);
      else begin
        band_t b;
        b = band_q.pop_front();
        check("band_power", band_power, b.band);
`ifdef FFT_POWER_PEAK_EN
        check("peak_bin", peak_bin, b.pk_bin);
        check("peak_power", peak_power, b.pk_pwr);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    for (int k = 0; k < NB; k++) mdl_acc[k] = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_real = '0; in_imag = '0; band_lo = '0; band_hi = 3'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_power", out_power, 0);
    check("rst_band_valid", band_valid, 0);
    check("rst_band_power", band_power, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk); #1;

    // ramp spectrum, full band
    run_spectrum(0, 0, 7, 1'b0, 1'b0);
    // constant |X|^2 = 25, inner band then inverted band
    run_spectrum(1, 2, 5, 1'b0, 1'b0);
    run_spectrum(1, 5, 2, 1'b0, 1'b0);
    // full-scale negative inputs
    run_spectrum(2, 0, 7, 1'b0, 1'b0);
    // downstream stalls and upstream pushes while draining
    run_spectrum(0, 0, 7, 1'b1, 1'b1);

    // malformed frames are flagged and excluded
    send_frame(0, 1);
    repeat (2) @(posedge clk);
    #1 check("frame_err_early_last", err_pulses, 1);
    send_frame(0, 2);
    repeat (2) @(posedge clk);
    #1 check("frame_err_missing_last", err_pulses, 2);
    run_spectrum(0, 0, 7, 1'b0, 1'b0);

    // reset in the middle of a drain
    band_lo = 3'd0; band_hi = 3'd7;
    for (int f = 0; f < (1 << AL); f++) send_frame(0, 0);
    expect_drain(4, 1'b0, 0, 7);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_bin == 3'd3) hit = 1'b1;
    end
    if (!hit) check("bin3_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    run_spectrum(0, 0, 7, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_left", sb_q.size(), 0);
    check("band_left", band_q.size(), 0);
    check("frame_err_total", err_pulses, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_power_avg.md
Name: fft_power_avg

Overview:
- Streaming power-spectrum averager placed directly after the FFT core.
- Accepts complex bins serially, one per cycle, and computes |X|^2 per bin.
- Accumulates each bin over 2^AVG_LOG2 frames, then drains the averaged spectrum serially with a valid/ready handshake.
- Generalises fixed-size 8-bin power summation: parametrised bins and width, runtime band selection replacing a fixed half-select, and frame averaging.

Parameters:
- DATA_W, 24, signed width of bin real/imag.
- NBINS, 8, bins per frame; must be >=2.
- AVG_LOG2, 2, log2 of frames averaged per output spectrum.
- PWR_W, 2*DATA_W+1, width of one bin power (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  bin present
- in_ready  out  1  block accepts bin
- in_real  in  DATA_W  signed bin real
- in_imag  in  DATA_W  signed bin imag
- in_last  in  1  marks final bin of frame
- band_lo  in  clog2(NBINS)  first bin of band sum
- band_hi  in  clog2(NBINS)  last bin of band sum
- out_valid  out  1  averaged bin present
- out_ready  in  1  downstream accepts
- out_power  out  PWR_W  averaged power of current bin
- out_bin  out  clog2(NBINS)  bin index of out_power
- out_last  out  1  final bin of drained spectrum
- band_valid  out  1  one-cycle pulse, band_power updated
- band_power  out  PWR_W+clog2(NBINS)  sum of averaged powers over band_lo..band_hi
- frame_err  out  1  one-cycle pulse on in_last/bin-count mismatch
- peak_bin  out  clog2(NBINS)  see Optional Feature
- peak_power  out  PWR_W  see Optional Feature

Behaviour:
- Reset: every output 0 except in_ready=1; all accumulators, bin and frame counters 0; state ACCUM. A reset mid-operation abandons the frame or drain; out_valid is 0 the cycle after rst.
- Squaring uses a 2-stage pipeline:
  - Stage 1 registers re*re and im*im (signed, 2*DATA_W each).
  - Stage 2 forms the PWR_W sum and adds it into acc[bin]. Accumulator width is PWR_W+AVG_LOG2, so it cannot overflow.
  - A bin accepted at cycle T is reflected in acc at T+2. Consecutive bins hit distinct entries (NBINS>=2), so there is no RMW hazard.
- Bin counter increments per accepted bin:
  - in_last with counter==NBINS-1 ends a normal frame.
  - in_last with counter!=NBINS-1, or counter==NBINS-1 without in_last: pulse frame_err, discard the current frame's contribution, and reset the counter to 0. The frame is not counted.
- States:
  - ACCUM: in_ready=1. Completion of the 2^AVG_LOG2-th good frame -> FLUSH.
  - FLUSH: in_ready=0; hold 2 cycles for the pipeline to empty; sample band_lo/band_hi -> DRAIN.
  - DRAIN: in_ready=0.
    - out_valid=1, out_bin runs 0..NBINS-1, out_power = acc[out_bin] >> AVG_LOG2 (truncating).
    - Advance only on out_valid&&out_ready; all outputs hold stable while stalled.
    - Each drained entry is cleared to 0.
    - out_last is set on bin NBINS-1; the handshake on it -> ACCUM, with band_valid pulsing the same cycle.
- Band sum accumulates out_power for bins within [band_lo, band_hi] during DRAIN; band_lo>band_hi gives band_power=0. band_power holds until the next band_valid.
- in_valid while in_ready=0 is ignored; no data is lost upstream.

Optional Feature:
- Macro FFT_POWER_PEAK_EN.
- Defined: during DRAIN track the maximum out_power. Ties keep the lowest bin. peak_bin/peak_power update together with band_valid.
- Undefined: peak_bin and peak_power are tied to 0 and no comparator logic is present.

Decomposition:
- Package fft_power_pkg:
  - State enum (ACCUM, FLUSH, DRAIN).
  - Width functions for PWR_W, accumulator width and band width.
  - clog2 helper.
- Sub-module cplx_mag2: 2-stage registered re^2+im^2 with a valid pipe.

Test Plan:
- 4 frames, bin k: re=k, im=0 (NBINS=8, AVG_LOG2=2), band 0..7, out_ready=1 -> out_power 0,1,4,9,16,25,36,49; out_last on bin 7; band_power=140, band_valid one cycle.
- All bins re=-3, im=4, band 2..5 -> every out_power=25; band_power=100; band_lo=5, band_hi=2 -> band_power=0.
- All bins re=im=-2^23 for 4 frames -> out_power=2^47 exactly, no wrap.
- out_ready toggled 1010 during DRAIN -> each bin presented until accepted, no duplicates or skips; in_ready=0 throughout DRAIN; in_valid pulses ignored.
- in_last on bin 5 -> frame_err pulse; that frame is excluded; the next 4 good frames give the same results as the first scenario.
- rst asserted at DRAIN bin 3 -> next cycle out_valid=0, in_ready=1; a fresh 4-frame run matches the first scenario with no stale accumulation.
- With FFT_POWER_PEAK_EN, first scenario -> peak_bin=7, peak_power=49.
